// File: rtl/coherence_bus_arbiter_pkg.sv
// Shared constants for the coherence data bus: word width, idle pattern,
// directory port index and the arbiter state encodings.
package coherence_bus_arbiter_pkg;

    localparam int CDB_WIDTH = 22;
    localparam logic [CDB_WIDTH-1:0] CDB_IDLE = {CDB_WIDTH{1'b1}};
    localparam int DIR_PORT = 0;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        WAIT_REPLY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/coherence_bus_arbiter_rr_picker.sv
// Combinational round-robin selector: returns the first eligible port at or
// after rr_ptr (wrapping), as both a one-hot vector and an index.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] pick_onehot,
    output logic [IDX_W-1:0] pick_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Walk the ports in priority order starting at rr_ptr; first hit wins.
    always_comb begin
        pick_onehot = '0;
        pick_idx    = '0;
        found       = 1'b0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            if (!found && eligible[cand]) begin
                pick_onehot[cand] = 1'b1;
                pick_idx          = cand;
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Coherence bus arbiter: grants one word per GRANT cycle onto cdb, keeps the
// bus closed to processors while a transaction waits for the directory reply,
// and aborts that wait after TIMEOUT silent cycles.
// Handshake: a port's request is live while req_valid is high and its word is
// not the idle pattern; grant is a one-cycle pulse in the cycle the word is on
// cdb, and the requester drops req_valid or advances its word the cycle after.
module coherence_bus_arbiter
    import coherence_bus_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = CDB_WIDTH,
    parameter int TIMEOUT = 15
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_msg,
    input  logic [N_REQ-1:0]           req_wait_reply,
    output logic [N_REQ-1:0]           grant,
    output logic [WIDTH-1:0]           cdb,
    output logic [$clog2(N_REQ)-1:0]   cdb_owner,
    output logic                       busy,
    output logic                       abort,
    output logic [1:0]                 dbg_state
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WIDTH-1:0] IDLE_WORD = {WIDTH{1'b1}};
    localparam logic [IDX_W-1:0] DIR_IDX   = IDX_W'(DIR_PORT);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [N_REQ-1:0] DIR_MASK  = N_REQ'(1) << DIR_PORT;

    arb_state_e       state, state_n;
    logic [WIDTH-1:0] word_q, word_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic             wr_q, wr_n;
    logic [IDX_W-1:0] rr_ptr, rr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             abort_q, abort_n;

    logic [N_REQ-1:0] eligible_raw, eligible;
    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic [WIDTH-1:0] pick_msg;
    logic             pick_wr;

    // Eligibility: valid and not the idle word; only the directory may win
    // while a transaction is waiting for its reply.
    always_comb begin
        eligible_raw = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible_raw[i] = req_valid[i] && (req_msg[i*WIDTH +: WIDTH] != IDLE_WORD);
        end
        eligible = (state == WAIT_REPLY) ? (eligible_raw & DIR_MASK) : eligible_raw;
    end

    rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
        .eligible    (eligible),
        .rr_ptr      (rr_ptr),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx)
    );

    // Mux out the winning port's word and wait-reply flag.
    always_comb begin
        pick_msg = IDLE_WORD;
        pick_wr  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_onehot[i]) begin
                pick_msg = req_msg[i*WIDTH +: WIDTH];
                pick_wr  = req_wait_reply[i];
            end
        end
    end

    // Next-state logic for the arbiter FSM and its datapath registers.
    always_comb begin
        state_n = state;
        word_n  = word_q;
        idx_n   = idx_q;
        wr_n    = wr_q;
        rr_n    = rr_ptr;
        cnt_n   = cnt;
        abort_n = 1'b0;
        case (state)
            IDLE: begin
                if (|pick_onehot) begin
                    word_n  = pick_msg;
                    idx_n   = pick_idx;
                    wr_n    = pick_wr;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                rr_n = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                // The directory never opens a transaction of its own.
                if (wr_q && (idx_q != DIR_IDX)) begin
                    state_n = WAIT_REPLY;
                    cnt_n   = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            WAIT_REPLY: begin
                if (|pick_onehot) begin
                    word_n  = pick_msg;
                    idx_n   = pick_idx;
                    wr_n    = pick_wr;
                    state_n = GRANT;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt_n == TIMEOUT_C) begin
                        abort_n = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            word_q  <= IDLE_WORD;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            rr_ptr  <= '0;
            cnt     <= '0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_n;
            word_q  <= word_n;
            idx_q   <= idx_n;
            wr_q    <= wr_n;
            rr_ptr  <= rr_n;
            cnt     <= cnt_n;
            abort_q <= abort_n;
        end
    end

    // Bus outputs are pure functions of the registered state.
    always_comb begin
        cdb       = (state == GRANT) ? word_q : IDLE_WORD;
        grant     = (state == GRANT) ? (N_REQ'(1) << idx_q) : '0;
        busy      = (state == GRANT) || (state == WAIT_REPLY);
        abort     = abort_q;
        cdb_owner = idx_q;
        dbg_state = state;
    end

endmodule
